// File: rtl/alu_pkg.sv
// Shared decode constants and the registered ALU control bundle.
package alu_pkg;
  localparam int DATA_W = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [DATA_W-1:0] in0;
    logic [DATA_W-1:0] in1;
    logic [2:0]        func3;
    logic              sub;
    logic              alu_en;
    logic [4:0]        rd;
    logic              illegal;
  } alu_bundle_t;

  function automatic logic [DATA_W-1:0] sext12(input logic [11:0] imm);
    return {{(DATA_W-12){imm[11]}}, imm};
  endfunction
endpackage

// File: rtl/alu_operand_stage_if.sv
// Issue-side and ALU-side signals of the operand stage; slave is the stage itself.
interface alu_operand_stage_if;
  logic        FLUSH;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] INSTR;
  logic [4:0]  RS1_ADDR;
  logic [4:0]  RS2_ADDR;
  logic [31:0] RS1_DATA;
  logic [31:0] RS2_DATA;
  logic [31:0] ALU_RESULT;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] IN0;
  logic [31:0] IN1;
  logic [2:0]  FUNC3;
  logic        SUB;
  logic        ALU_EN;
  logic [4:0]  RD;
  logic        ILLEGAL;

  modport master (
    output FLUSH, IN_VALID, INSTR, RS1_DATA, RS2_DATA, ALU_RESULT, OUT_READY,
    input  IN_READY, RS1_ADDR, RS2_ADDR, OUT_VALID, IN0, IN1, FUNC3, SUB, ALU_EN, RD, ILLEGAL
  );

  modport slave (
    input  FLUSH, IN_VALID, INSTR, RS1_DATA, RS2_DATA, ALU_RESULT, OUT_READY,
    output IN_READY, RS1_ADDR, RS2_ADDR, OUT_VALID, IN0, IN1, FUNC3, SUB, ALU_EN, RD, ILLEGAL
  );
endinterface

// File: rtl/alu_decode.sv
// Combinational RV32I OP/OP-IMM decode of one instruction plus its (already bypassed) operands.
// Zero latency; no handshake of its own.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] i_instr,
  input  logic [31:0] i_rs1_dat,
  input  logic [31:0] i_rs2_dat,
  output logic [4:0]  o_rs1_addr,
  output logic [4:0]  o_rs2_addr,
  output alu_bundle_t o_bundle
);
  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_alt_ok;
  logic       w_legal;

  // Kept as plain assigns so the address-to-bypass path is not a false comb loop.
  assign o_rs1_addr = i_instr[19:15];
  assign o_rs2_addr = i_instr[24:20];
  assign w_opc      = i_instr[6:0];
  assign w_f3       = i_instr[14:12];
  assign w_f7       = i_instr[31:25];

  always_comb begin
    w_alt_ok = 1'b0;
    case (w_f3)
      F3_ADD, F3_SR:                               w_alt_ok = 1'b1;
      F3_SLL, F3_SLT, F3_SLTU, F3_XOR, F3_OR, F3_AND: w_alt_ok = 1'b0;
      default:                                     w_alt_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_legal  = 1'b0;
    o_bundle = '{in0: i_rs1_dat, in1: i_rs2_dat, func3: w_f3, sub: 1'b0,
                 alu_en: 1'b0, rd: i_instr[11:7], illegal: 1'b0};
    if (w_opc == OPC_OP) begin
      w_legal          = (w_f7 == F7_BASE) || ((w_f7 == F7_ALT) && w_alt_ok);
      o_bundle.sub     = w_alt_ok & i_instr[30];
      o_bundle.alu_en  = w_legal;
      o_bundle.illegal = !w_legal;
    end else if (w_opc == OPC_OP_IMM) begin
      case (w_f3)
        F3_SLL:  w_legal = (w_f7 == F7_BASE);
        F3_SR:   w_legal = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
        default: w_legal = 1'b1;
      endcase
      o_bundle.in1     = sext12(i_instr[31:20]);
      o_bundle.sub     = (w_f3 == F3_SR) & i_instr[30];
      o_bundle.alu_en  = w_legal;
      o_bundle.illegal = !w_legal;
    end
  end
endmodule

// File: rtl/alu_operand_stage.sv
// Decode/issue stage in front of the ALU: bypass, decode, register; 1-cycle latency.
// One-entry skid keeps IN_READY registered (= skid empty); outputs hold while stalled.
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                CLK,
  input  logic                RST_N,
  alu_operand_stage_if.slave  bus
);
  alu_bundle_t     r_out;
  alu_bundle_t     r_skid;
  logic            r_out_vld;
  logic            r_skid_vld;
  alu_bundle_t     w_dec;
  logic [4:0]      w_rs1_addr;
  logic [4:0]      w_rs2_addr;
  logic [XLEN-1:0] w_rs1_op;
  logic [XLEN-1:0] w_rs2_op;
  logic            w_fwd_ok;
  logic            w_accept;
  logic            w_handoff;

  // The held bundle is always the immediately preceding instruction at accept time.
  assign w_fwd_ok  = r_out_vld && r_out.alu_en && (r_out.rd != 5'd0);
  assign w_rs1_op  = (w_fwd_ok && (r_out.rd == w_rs1_addr)) ? bus.ALU_RESULT : bus.RS1_DATA;
  assign w_rs2_op  = (w_fwd_ok && (r_out.rd == w_rs2_addr)) ? bus.ALU_RESULT : bus.RS2_DATA;
  assign w_accept  = bus.IN_VALID && !r_skid_vld;
  assign w_handoff = r_out_vld && bus.OUT_READY;

  alu_decode u_decode (
    .i_instr    (bus.INSTR),
    .i_rs1_dat  (w_rs1_op),
    .i_rs2_dat  (w_rs2_op),
    .o_rs1_addr (w_rs1_addr),
    .o_rs2_addr (w_rs2_addr),
    .o_bundle   (w_dec)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_out      <= '0;
      r_skid     <= '0;
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (bus.FLUSH) begin
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (!r_out_vld || w_handoff) begin
      if (r_skid_vld) begin
        r_out      <= r_skid;
        r_out_vld  <= 1'b1;
        r_skid_vld <= 1'b0;
      end else begin
        r_out_vld <= w_accept;
        if (w_accept) r_out <= w_dec;
      end
    end else if (w_accept) begin
      r_skid     <= w_dec;
      r_skid_vld <= 1'b1;
    end
  end

  assign bus.RS1_ADDR  = w_rs1_addr;
  assign bus.RS2_ADDR  = w_rs2_addr;
  assign bus.IN_READY  = !r_skid_vld;
  assign bus.OUT_VALID = r_out_vld;
  assign bus.IN0       = r_out.in0;
  assign bus.IN1       = r_out.in1;
  assign bus.FUNC3     = r_out.func3;
  assign bus.SUB       = r_out.sub;
  assign bus.ALU_EN    = r_out.alu_en;
  assign bus.RD        = r_out.rd;
  assign bus.ILLEGAL   = r_out.illegal;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed checks followed by a randomized run against an in-order architectural model.
module tb_alu_operand_stage;
  import alu_pkg::*;

  logic CLK;
  logic RST_N;
  int   n_tests;
  int   n_fail;

  alu_operand_stage_if bus ();

  alu_operand_stage #(.XLEN(32)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [31:0] rf   [32];
  logic [31:0] arch [32];
  alu_bundle_t q [$];
  logic [31:0] got [$];
  alu_bundle_t e_b;
  alu_bundle_t h_b;
  logic [31:0] ins;
  logic        r_acc;
  logic        r_hand;
  int          n_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  function automatic alu_bundle_t mk(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                                     input logic s, input logic en, input logic [4:0] rd, input logic ill);
    alu_bundle_t r;
    r.in0 = a; r.in1 = b; r.func3 = f3; r.sub = s; r.alu_en = en; r.rd = rd; r.illegal = ill;
    return r;
  endfunction

  task automatic chk_bundle(input string tag, input alu_bundle_t e);
    chk({tag, "_in0"}, bus.IN0, e.in0);
    chk({tag, "_in1"}, bus.IN1, e.in1);
    chk({tag, "_ctl"}, {bus.FUNC3, bus.SUB, bus.ALU_EN, bus.RD, bus.ILLEGAL},
        {e.func3, e.sub, e.alu_en, e.rd, e.illegal});
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] d1, input logic [31:0] d2);
    bus.IN_VALID = 1'b1;
    bus.INSTR    = i;
    bus.RS1_DATA = d1;
    bus.RS2_DATA = d2;
  endtask

  // What an RV32I ALU produces for a bundle.
  function automatic logic [31:0] alu(input alu_bundle_t x);
    case (x.func3)
      3'd0: return x.sub ? x.in0 - x.in1 : x.in0 + x.in1;
      3'd1: return x.in0 << x.in1[4:0];
      3'd2: return {31'd0, $signed(x.in0) < $signed(x.in1)};
      3'd3: return {31'd0, x.in0 < x.in1};
      3'd4: return x.in0 ^ x.in1;
      3'd5: return x.sub ? $unsigned($signed(x.in0) >>> x.in1[4:0]) : x.in0 >> x.in1[4:0];
      3'd6: return x.in0 | x.in1;
      default: return x.in0 & x.in1;
    endcase
  endfunction

  // Expected bundle given the architectural values of rs1/rs2.
  function automatic alu_bundle_t ref_bundle(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    alu_bundle_t r;
    logic [2:0] f3;
    logic [6:0] f7;
    logic ok;
    f3 = i[14:12];
    f7 = i[31:25];
    r = mk(a, b, f3, 1'b0, 1'b0, i[11:7], 1'b0);
    ok = 1'b0;
    if (i[6:0] == 7'h33) begin
      ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      r.sub = (f3 == 3'd0 || f3 == 3'd5) && i[30];
    end else if (i[6:0] == 7'h13) begin
      if (f3 == 3'd1) ok = (f7 == 7'h00);
      else if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
      else ok = 1'b1;
      r.in1 = {{20{i[31]}}, i[31:20]};
      r.sub = (f3 == 3'd5) && i[30];
    end
    r.alu_en  = ok;
    r.illegal = !ok;
    return r;
  endfunction

  function automatic logic [31:0] gen();
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [6:0] f7;
    int sel;
    rd  = 5'($urandom_range(0, 3));
    rs1 = 5'($urandom_range(0, 3));
    rs2 = 5'($urandom_range(0, 3));
    f3  = 3'($urandom_range(0, 7));
    sel = $urandom_range(0, 9);
    if (sel < 5) f7 = 7'h00;
    else if (sel < 9) f7 = 7'h20;
    else f7 = 7'($urandom_range(1, 127));
    if ($urandom_range(0, 1) == 1) return {f7, rs2, rs1, f3, rd, 7'h33};
    if (f3 == 3'd1 || f3 == 3'd5) return {f7, rs2, rs1, f3, rd, 7'h13};
    return {12'($urandom), rs1, f3, rd, 7'h13};
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    RST_N = 1'b0;
    bus.FLUSH = 1'b0; bus.IN_VALID = 1'b0; bus.INSTR = '0;
    bus.RS1_DATA = '0; bus.RS2_DATA = '0; bus.ALU_RESULT = '0; bus.OUT_READY = 1'b1;
    cyc();
    cyc();
    chk("rst_out_valid", bus.OUT_VALID, 1'b0);
    chk("rst_in_ready", bus.IN_READY, 1'b1);
    chk_bundle("rst", mk(0, 0, 0, 0, 0, 0, 0));

    // First accept on the first edge after release; address ports are combinational.
    RST_N = 1'b1;
    drive(32'hFFB00093, 0, 0);
    #1;
    chk("rs1_addr", bus.RS1_ADDR, 5'd0);
    chk("rs2_addr", bus.RS2_ADDR, 5'd27);
    cyc(); bus.IN_VALID = 1'b0;
    chk("addi_vld", bus.OUT_VALID, 1'b1);
    chk_bundle("addi", mk(0, 32'hFFFFFFFB, 3'd0, 0, 1, 5'd1, 0));
    cyc();
    chk("drain_vld", bus.OUT_VALID, 1'b0);

    drive(32'h402081B3, 10, 3); cyc(); bus.IN_VALID = 1'b0;
    chk_bundle("sub", mk(10, 3, 3'd0, 1, 1, 5'd3, 0)); cyc();
    drive(32'h4042D293, 7, 0); cyc(); bus.IN_VALID = 1'b0;
    chk("srai_shamt", bus.IN1[4:0], 5'd4);
    chk_bundle("srai", mk(7, 32'h404, 3'd5, 1, 1, 5'd5, 0)); cyc();
    drive(32'h022081B3, 10, 3); cyc(); bus.IN_VALID = 1'b0;
    chk_bundle("op_ill", mk(10, 3, 3'd0, 0, 0, 5'd3, 1)); cyc();
    drive(32'h40339313, 32'h77, 0); cyc(); bus.IN_VALID = 1'b0;
    chk_bundle("slli_ill", mk(32'h77, 32'h403, 3'd1, 0, 0, 5'd6, 1)); cyc();
    drive(32'h123452B7, 32'hAA, 32'hBB); cyc(); bus.IN_VALID = 1'b0;
    chk_bundle("lui", mk(32'hAA, 32'hBB, 3'd5, 0, 0, 5'd5, 0)); cyc();

    // Bypass from the held ADD x1, with handoff in the same cycle.
    drive(32'h003100B3, 0, 0); cyc();
    bus.ALU_RESULT = 32'h1234;
    drive(32'h00108233, 0, 0); cyc(); bus.IN_VALID = 1'b0;
    chk_bundle("byp", mk(32'h1234, 32'h1234, 3'd0, 0, 1, 5'd4, 0));
    bus.ALU_RESULT = 0; cyc();
    drive(32'h00310033, 0, 0); cyc();
    bus.ALU_RESULT = 32'h1234;
    drive(32'h00000233, 32'h55, 32'h66); cyc(); bus.IN_VALID = 1'b0;
    chk_bundle("byp_x0", mk(32'h55, 32'h66, 3'd0, 0, 1, 5'd4, 0));
    bus.ALU_RESULT = 0; cyc();

    // Backpressure: head held, second in skid, third waits.
    bus.OUT_READY = 1'b0;
    drive(32'h00100093, 0, 0); cyc();
    chk("bp_rdy0", bus.IN_READY, 1'b1); chk("bp_head0", bus.IN1, 32'd1);
    drive(32'h00200113, 0, 0); cyc();
    chk("bp_rdy1", bus.IN_READY, 1'b0); chk("bp_head1", bus.IN1, 32'd1);
    drive(32'h00300193, 0, 0); cyc();
    chk("bp_rdy2", bus.IN_READY, 1'b0); chk("bp_head2", bus.IN1, 32'd1);
    chk("bp_vld", bus.OUT_VALID, 1'b1);
    bus.OUT_READY = 1'b1;
    got.delete();
    for (int i = 0; i < 8; i++) begin
      if (bus.OUT_VALID) got.push_back(bus.IN1);
      r_acc = bus.IN_VALID && bus.IN_READY;
      cyc();
      if (r_acc) bus.IN_VALID = 1'b0;
    end
    chk("bp_count", got.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < got.size()) chk($sformatf("bp_order%0d", i), got[i], i + 1);

    // Flush with output and skid full and a pending input.
    bus.OUT_READY = 1'b0;
    drive(32'h00100093, 0, 0); cyc();
    drive(32'h00200113, 0, 0); cyc();
    drive(32'h00300193, 0, 0); bus.FLUSH = 1'b1; cyc();
    bus.FLUSH = 1'b0; bus.IN_VALID = 1'b0;
    chk("fl_vld", bus.OUT_VALID, 1'b0);
    chk("fl_rdy", bus.IN_READY, 1'b1);
    bus.OUT_READY = 1'b1;
    n_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.OUT_VALID) n_seen++;
      cyc();
    end
    chk("fl_none", n_seen, 0);
    // Flush drops an instruction accepted in the same cycle.
    bus.OUT_READY = 1'b0;
    drive(32'h00100093, 0, 0); cyc();
    drive(32'h00200113, 0, 0); bus.FLUSH = 1'b1; cyc();
    bus.FLUSH = 1'b0; bus.IN_VALID = 1'b0;
    chk("fl2_vld", bus.OUT_VALID, 1'b0);
    chk("fl2_rdy", bus.IN_READY, 1'b1);

    // Asynchronous reset mid-stall.
    drive(32'h00100093, 0, 0); cyc();
    drive(32'h00200113, 0, 0); cyc(); bus.IN_VALID = 1'b0;
    chk("rs_pre_rdy", bus.IN_READY, 1'b0);
    #2 RST_N = 1'b0;
    #1;
    chk("rs_vld", bus.OUT_VALID, 1'b0);
    chk("rs_rdy", bus.IN_READY, 1'b1);
    chk_bundle("rs", mk(0, 0, 0, 0, 0, 0, 0));
    @(negedge CLK);
    RST_N = 1'b1; bus.OUT_READY = 1'b1;
    drive(32'h00300193, 0, 0); cyc(); bus.IN_VALID = 1'b0;
    chk("rs_first_vld", bus.OUT_VALID, 1'b1);
    chk("rs_first_in1", bus.IN1, 32'd3);
    cyc();

    // Random traffic: operands must equal in-order architectural register values.
    q.delete();
    for (int i = 0; i < 32; i++) begin
      rf[i] = '0;
      arch[i] = '0;
    end
    for (int c = 0; c < 600; c++) begin
      chk("r_vld", bus.OUT_VALID, q.size() != 0);
      chk("r_rdy", bus.IN_READY, q.size() < 2);
      if (q.size() != 0) chk_bundle("r", q[0]);
      ins = gen();
      bus.INSTR      = ins;
      bus.IN_VALID   = ($urandom_range(0, 3) != 0);
      bus.OUT_READY  = ($urandom_range(0, 3) != 0);
      bus.RS1_DATA   = rf[ins[19:15]];
      bus.RS2_DATA   = rf[ins[24:20]];
      bus.ALU_RESULT = (q.size() != 0) ? alu(q[0]) : $urandom;
      r_acc  = bus.IN_VALID && (q.size() < 2);
      r_hand = (q.size() != 0) && bus.OUT_READY;
      if (r_hand) begin
        h_b = q.pop_front();
        if (h_b.alu_en && h_b.rd != 5'd0) rf[h_b.rd] = alu(h_b);
      end
      if (r_acc) begin
        e_b = ref_bundle(ins, arch[ins[19:15]], arch[ins[24:20]]);
        q.push_back(e_b);
        if (e_b.alu_en && e_b.rd != 5'd0) arch[e_b.rd] = alu(e_b);
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

- Decode/issue stage directly upstream of `ALU_DataPath`.
- Accepts RV32I instructions together with their register-file read data over a valid/ready handshake.
- Decodes OP and OP-IMM into the ALU control set (IN0, IN1, FUNC3, SUB, ALU_EN), bypasses the previous instruction's ALU result, and registers the bundle.
- A one-entry skid buffer keeps IN_READY registered, so throughput is one instruction per cycle.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- FLUSH  in  1  synchronous; drops every held and incoming instruction.
- IN_VALID  in  1  INSTR/RS1_DATA/RS2_DATA valid.
- IN_READY  out  1  stage can accept; registered, equals "skid empty".
- INSTR  in  32  raw instruction.
- RS1_ADDR, RS2_ADDR  out  5  INSTR[19:15], INSTR[24:20]; combinational, to the register file.
- RS1_DATA, RS2_DATA  in  32  register-file read data for the current INSTR.
- ALU_RESULT  in  32  ALU OUT for the bundle currently held on the outputs; bypass source.
- OUT_VALID  out  1  output bundle valid.
- OUT_READY  in  1  downstream accepts the bundle.
- IN0, IN1  out  32  ALU operands.
- FUNC3  out  3  ALU function select.
- SUB  out  1  subtract for ADD/SUB; arithmetic shift for the 101 shifts.
- ALU_EN  out  1  bundle is a legal OP/OP-IMM instruction.
- RD  out  5  destination register, INSTR[11:7].
- ILLEGAL  out  1  OP/OP-IMM with an unsupported funct7/imm[11:5].

## Operation
Decode rules:
- OP (0110011):
  - IN0=rs1, IN1=rs2, FUNC3=INSTR[14:12].
  - SUB=INSTR[30] when FUNC3 is 000 or 101, else 0.
  - funct7 must be 0000000, or 0100000 with FUNC3 of 000 or 101.
- OP-IMM (0010011):
  - IN0=rs1, IN1=sign-extended INSTR[31:20].
  - SUB=INSTR[30] only when FUNC3=101.
  - SLLI requires imm[11:5]=0000000.
  - SRLI/SRAI require imm[11:5] to be 0000000 or 0100000.
  - IN1[4:0] carries shamt.
- Illegal encodings: ALU_EN=0, ILLEGAL=1; all other fields decoded as above.
- Other opcodes: ALU_EN=0, ILLEGAL=0, IN0=RS1_DATA, IN1=RS2_DATA, SUB=0, FUNC3 passed through.

Operand bypass:
- Applied to rs1 and rs2 independently, at the moment of acceptance.
- Condition: OUT_VALID && ALU_EN && RD!=0 && RD==source address.
- When the condition holds, the operand is ALU_RESULT instead of RSx_DATA.
- Bypass still applies when the held bundle hands off in the same cycle.
- Contract: the register-file write of a bundle leaving the outputs is visible on RSx_DATA from the next cycle.

Buffering and handshake:
- Accept = IN_VALID && IN_READY.
- Output register load rule:
  - Load from input when the output is empty, or when it hands off (OUT_VALID && OUT_READY) and the skid is empty.
  - Otherwise an accepted instruction goes to the skid.
- On handoff with the skid full, the skid moves to the output register; IN_READY returns to 1 the following cycle.
- Order is preserved; no drop or duplication except on FLUSH.
- FLUSH has highest priority: OUT_VALID and the skid valid bit clear at the next edge, and an instruction accepted in that cycle is discarded.

## Timing
- Latency: 1 cycle, accept edge to OUT_VALID, when not stalled.
- Throughput: 1 instruction per cycle while OUT_READY=1.
- All bundle outputs hold stable while OUT_VALID && !OUT_READY.
- Reset (RST_N low, asynchronous):
  - OUT_VALID=0, skid empty, IN_READY=1.
  - IN0=IN1=0, FUNC3=0, SUB=0, ALU_EN=0, RD=0, ILLEGAL=0.
- Reset mid-stall discards both entries.
- After RST_N rises, the first accept is possible on the first edge.
- RS1_ADDR/RS2_ADDR are pure combinational functions of INSTR.

## Structure
- Shared package `alu_pkg`:
  - Opcode constants: OPC_OP, OPC_OP_IMM.
  - FUNC3 constants: ADD, SLL, SLT, SLTU, XOR, SR, OR, AND.
  - funct7 constants.
  - Packed struct `alu_bundle_t` {IN0, IN1, FUNC3, SUB, ALU_EN, RD, ILLEGAL}.
- Sub-module `alu_decode`: combinational INSTR + bypassed operands to `alu_bundle_t`, instantiated once.
- The top holds the output register, skid register, and valid bits.

## Test plan
- ADDI x1,x0,-5 (0xFFB00093), RS1_DATA=0 -> next cycle OUT_VALID=1, IN0=0, IN1=0xFFFFFFFB, FUNC3=000, SUB=0, ALU_EN=1, RD=1.
- SUB x3,x1,x2 (0x402081B3), RS1_DATA=10, RS2_DATA=3 -> IN0=10, IN1=3, SUB=1, FUNC3=000, RD=3.
- SRAI x5,x5,4 (0x4042D293) -> FUNC3=101, SUB=1, IN1[4:0]=4.
- Same opcode with funct7=0000001 -> ILLEGAL=1, ALU_EN=0.
- Bypass:
  - ADD x1 held with ALU_RESULT=0x1234, then ADD x4,x1,x1 with RS data 0 -> IN0=IN1=0x1234.
  - Repeat with RD=x0 -> operands taken from RS data.
- Backpressure: OUT_READY=0 for 3 cycles with 3 back-to-back instructions -> first held stable, second in skid, IN_READY=0; then OUT_READY=1 -> all 3 delivered in order, once each.
- FLUSH with output and skid full and IN_VALID=1 -> next cycle OUT_VALID=0, IN_READY=1, nothing delivered.
- RST_N pulsed mid-stall -> all outputs at reset values immediately.
